vsn_cable_plant_n: RTL and testbench

VSN_CABLE_PLANT_N -- requirements
Module: vsn_cable_plant_n

---
 rtl/vsn_cable_plant_n.sv | 130 +++++++++++++
 tb/tb_vsn_cable_plant_n.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsn_cable_plant_n.sv
// Cable plant emulator: each DAC stream runs through a fixed-length delay line,
// and a route/delay/mute crossbar taps those lines onto registered ADC streams.
module vsn_cable_plant_n #(
  parameter  int NCHAN     = 8,
  parameter  int DATA_W    = 32,
  parameter  int DELAY_MAX = 16,
  localparam int DLY_W     = $clog2(DELAY_MAX),
  localparam int SEL_W     = $clog2(NCHAN)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NCHAN*DATA_W-1:0] dac_tdata,
  input  logic [NCHAN-1:0]        dac_tvalid,
  output logic [NCHAN-1:0]        dac_tready,
  output logic [NCHAN*DATA_W-1:0] adc_tdata,
  output logic [NCHAN-1:0]        adc_tvalid,
  input  logic [NCHAN-1:0]        adc_tready,
  input  logic [NCHAN*SEL_W-1:0]  cfg_route,
  input  logic [NCHAN*DLY_W-1:0]  cfg_delay,
  input  logic [NCHAN-1:0]        cfg_mute,
  input  logic                    cfg_load,
  input  logic                    drop_clr,
  output logic [NCHAN*16-1:0]     drop_count
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t            line [NCHAN][DELAY_MAX];
  beat_t            tap [NCHAN];
  logic [SEL_W-1:0] route [NCHAN];
  logic [DLY_W-1:0] delay [NCHAN];
  logic [NCHAN-1:0] mute;
  logic [SEL_W-1:0] route_nxt [NCHAN];
  logic [DLY_W-1:0] delay_nxt [NCHAN];
  logic [15:0]      drops [NCHAN];
  logic             ready_q;

  // The cable never stalls the DAC side; ready only drops while in reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign dac_tready = {NCHAN{ready_q}};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      // NOTE: the delay-line storage is reset on purpose, so no beat accepted
      // before reset can ever be tapped out afterwards.
      for (int i = 0; i < NCHAN; i++)
        for (int s = 0; s < DELAY_MAX; s++)
          line[i][s] <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        // NOTE: non-blocking assignments make every stage shift simultaneously.
        line[i][0] <= {dac_tvalid[i], dac_tdata[i*DATA_W +: DATA_W]};
        for (int s = 1; s < DELAY_MAX; s++)
          line[i][s] <= line[i][s-1];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NCHAN; j++) begin
      // NOTE: defaults first so no path leaves a latch behind.
      route_nxt[j] = route[j];
      delay_nxt[j] = cfg_delay[j*DLY_W +: DLY_W];
      if (int'(cfg_route[j*SEL_W +: SEL_W]) < NCHAN)
        route_nxt[j] = cfg_route[j*SEL_W +: SEL_W];
      if (int'(cfg_delay[j*DLY_W +: DLY_W]) >= DELAY_MAX)
        delay_nxt[j] = DLY_W'(DELAY_MAX - 1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int j = 0; j < NCHAN; j++) begin
        route[j] <= SEL_W'(j);
        delay[j] <= '0;
      end
      mute <= '0;
    end else if (cfg_load) begin
      for (int j = 0; j < NCHAN; j++) begin
        route[j] <= route_nxt[j];
        delay[j] <= delay_nxt[j];
      end
      mute <= cfg_mute;
    end
  end

  always_comb begin
    for (int j = 0; j < NCHAN; j++)
      tap[j] = line[route[j]][delay[j]];
  end

  // The output register reloads every cycle; a beat not taken is simply lost.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      adc_tvalid <= '0;
      adc_tdata  <= '0;
    end else begin
      for (int j = 0; j < NCHAN; j++) begin
        adc_tvalid[j]                  <= tap[j].valid;
        adc_tdata[j*DATA_W +: DATA_W]  <= mute[j] ? '0 : tap[j].data;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int j = 0; j < NCHAN; j++) drops[j] <= '0;
    end else begin
      for (int j = 0; j < NCHAN; j++) begin
        if (drop_clr)
          drops[j] <= '0;
        else if (adc_tvalid[j] && !adc_tready[j] && drops[j] != 16'hFFFF)
          drops[j] <= drops[j] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NCHAN; j++)
      drop_count[j*16 +: 16] = drops[j];
  end

endmodule

// File: tb/tb_vsn_cable_plant_n.sv
// Bench for vsn_cable_plant_n: directed scenarios plus randomized traffic
// checked against a history-based model of the cable timing rules.
module tb_vsn_cable_plant_n;
  localparam int NCHAN     = 8;
  localparam int DATA_W    = 32;
  localparam int DELAY_MAX = 16;
  localparam int DLY_W     = 4;
  localparam int SEL_W     = 3;
  localparam int HN        = 32;
  // Second instance whose field widths can encode out-of-range route/delay.
  localparam int G_N       = 6;
  localparam int G_W       = 8;
  localparam int G_DMAX    = 12;

  logic                    aclk = 1'b0;
  logic                    areset = 1'b1;
  logic [NCHAN*DATA_W-1:0] dac_tdata = '0;
  logic [NCHAN-1:0]        dac_tvalid = '0;
  logic [NCHAN-1:0]        dac_tready;
  logic [NCHAN*DATA_W-1:0] adc_tdata;
  logic [NCHAN-1:0]        adc_tvalid;
  logic [NCHAN-1:0]        adc_tready = '1;
  logic [NCHAN*SEL_W-1:0]  cfg_route = '0;
  logic [NCHAN*DLY_W-1:0]  cfg_delay = '0;
  logic [NCHAN-1:0]        cfg_mute = '0;
  logic                    cfg_load = 1'b0;
  logic                    drop_clr = 1'b0;
  logic [NCHAN*16-1:0]     drop_count;

  logic [G_N*G_W-1:0] g_dac_tdata = '0;
  logic [G_N-1:0]     g_dac_tvalid = '0;
  logic [G_N-1:0]     g_dac_tready;
  logic [G_N*G_W-1:0] g_adc_tdata;
  logic [G_N-1:0]     g_adc_tvalid;
  logic [G_N*3-1:0]   g_cfg_route = '0;
  logic [G_N*4-1:0]   g_cfg_delay = '0;
  logic               g_cfg_load = 1'b0;
  logic [G_N*16-1:0]  g_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  vsn_cable_plant_n #(.NCHAN(NCHAN), .DATA_W(DATA_W), .DELAY_MAX(DELAY_MAX)) dut (
    .aclk(aclk), .areset(areset),
    .dac_tdata(dac_tdata), .dac_tvalid(dac_tvalid), .dac_tready(dac_tready),
    .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid), .adc_tready(adc_tready),
    .cfg_route(cfg_route), .cfg_delay(cfg_delay), .cfg_mute(cfg_mute),
    .cfg_load(cfg_load), .drop_clr(drop_clr), .drop_count(drop_count)
  );

  vsn_cable_plant_n #(.NCHAN(G_N), .DATA_W(G_W), .DELAY_MAX(G_DMAX)) dut_g (
    .aclk(aclk), .areset(areset),
    .dac_tdata(g_dac_tdata), .dac_tvalid(g_dac_tvalid), .dac_tready(g_dac_tready),
    .adc_tdata(g_adc_tdata), .adc_tvalid(g_adc_tvalid), .adc_tready({G_N{1'b1}}),
    .cfg_route(g_cfg_route), .cfg_delay(g_cfg_delay), .cfg_mute({G_N{1'b0}}),
    .cfg_load(g_cfg_load), .drop_clr(1'b0), .drop_count(g_drop_count)
  );

  // Reference model: remembers what each DAC offered at every edge and
  // applies "beat at edge k shows up at edge k+1+delay" directly.
  int                e;
  bit                hv [HN][NCHAN];
  logic [DATA_W-1:0] hd [HN][NCHAN];
  int                m_route [NCHAN];
  int                m_delay [NCHAN];
  bit                m_mute [NCHAN];
  bit                exp_v [NCHAN];
  logic [DATA_W-1:0] exp_d [NCHAN];
  int                exp_cnt [NCHAN];
  bit                exp_rdy;

  task automatic model_reset();
    e = 0;
    exp_rdy = 1'b0;
    for (int j = 0; j < NCHAN; j++) begin
      m_route[j] = j; m_delay[j] = 0; m_mute[j] = 1'b0;
      exp_v[j] = 1'b0; exp_d[j] = '0; exp_cnt[j] = 0;
    end
  endtask

  task automatic model_edge();
    bit                nv [NCHAN];
    logic [DATA_W-1:0] nd [NCHAN];
    for (int j = 0; j < NCHAN; j++) begin
      int src = e - 1 - m_delay[j];
      nv[j] = 1'b0;
      nd[j] = '0;
      if (src >= 0) begin
        nv[j] = hv[src % HN][m_route[j]];
        nd[j] = m_mute[j] ? '0 : hd[src % HN][m_route[j]];
      end
      if (drop_clr) exp_cnt[j] = 0;
      else if (exp_v[j] && !adc_tready[j] && exp_cnt[j] < 65535) exp_cnt[j]++;
    end
    for (int j = 0; j < NCHAN; j++) begin
      exp_v[j] = nv[j];
      exp_d[j] = nd[j];
      hv[e % HN][j] = dac_tvalid[j];
      hd[e % HN][j] = dac_tdata[j*DATA_W +: DATA_W];
    end
    if (cfg_load) begin
      for (int j = 0; j < NCHAN; j++) begin
        int r = int'(cfg_route[j*SEL_W +: SEL_W]);
        int d = int'(cfg_delay[j*DLY_W +: DLY_W]);
        if (r < NCHAN) m_route[j] = r;
        m_delay[j] = (d >= DELAY_MAX) ? DELAY_MAX - 1 : d;
        m_mute[j]  = cfg_mute[j];
      end
    end
    exp_rdy = 1'b1;
    e++;
  endtask

  task automatic step();
    @(posedge aclk);
    if (!areset) model_edge();
    #1;
  endtask

  task automatic idle();
    dac_tvalid = '0;
    dac_tdata  = '0;
  endtask

  function automatic logic [NCHAN*SEL_W-1:0] ident_route();
    logic [NCHAN*SEL_W-1:0] r;
    for (int j = 0; j < NCHAN; j++) r[j*SEL_W +: SEL_W] = SEL_W'(j);
    return r;
  endfunction

  // Load a configuration, then scramble the cfg_* inputs: they must be ignored.
  task automatic load_cfg(input logic [NCHAN*SEL_W-1:0] r,
                          input logic [NCHAN*DLY_W-1:0] d,
                          input logic [NCHAN-1:0] m);
    cfg_route = r; cfg_delay = d; cfg_mute = m; cfg_load = 1'b1;
    step();
    cfg_load  = 1'b0;
    cfg_route = (NCHAN*SEL_W)'($urandom);
    cfg_delay = (NCHAN*DLY_W)'($urandom);
    cfg_mute  = NCHAN'($urandom);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    n_checks++; if (dac_tready !== '0) begin n_fail++; $display("FAIL rst_tready: got %b expected 0", dac_tready); end
    n_checks++; if (adc_tvalid !== '0) begin n_fail++; $display("FAIL rst_adc_valid: got %b expected 0", adc_tvalid); end
    n_checks++; if (adc_tdata !== '0) begin n_fail++; $display("FAIL rst_adc_data: got %h expected 0", adc_tdata); end
    n_checks++; if (drop_count !== '0) begin n_fail++; $display("FAIL rst_drop_count: got %h expected 0", drop_count); end
    areset = 1'b0;
    n_checks++; if (dac_tready !== '0) begin n_fail++; $display("FAIL rel_tready_early: got %b expected 0", dac_tready); end
    step();
    n_checks++; if (dac_tready !== '1) begin n_fail++; $display("FAIL rel_tready_first_edge: got %b expected all 1", dac_tready); end
    n_checks++; if (adc_tvalid !== '0) begin n_fail++; $display("FAIL rel_adc_valid: got %b expected 0", adc_tvalid); end
  endtask

  task automatic test_single_beat();
    repeat (8) step();
    dac_tvalid = 8'b0000_1000;
    dac_tdata[3*DATA_W +: DATA_W] = 32'hA5A5_0001;
    step();
    idle();
    n_checks++; if (adc_tvalid !== '0) begin n_fail++; $display("FAIL single_early: got %b expected 0", adc_tvalid); end
    step();
    n_checks++; if (adc_tvalid !== 8'b0000_1000) begin n_fail++; $display("FAIL single_valid: got %b expected 00001000", adc_tvalid); end
    n_checks++; if (adc_tdata[3*DATA_W +: DATA_W] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got %h expected a5a50001", adc_tdata[3*DATA_W +: DATA_W]); end
    step();
    n_checks++; if (adc_tvalid !== '0) begin n_fail++; $display("FAIL single_once: got %b expected 0", adc_tvalid); end
  endtask

  task automatic test_route_delay();
    logic [NCHAN*SEL_W-1:0] r = ident_route();
    logic [NCHAN*DLY_W-1:0] d = '0;
    r[0 +: SEL_W] = 3'd5;
    d[0 +: DLY_W] = 4'd7;
    load_cfg(r, d, '0);
    for (int t = 0; t < 14; t++) begin
      bit                v5, v0;
      logic [DATA_W-1:0] d5, d0;
      idle();
      if (t < 4) begin
        dac_tvalid[5] = 1'b1;
        dac_tdata[5*DATA_W +: DATA_W] = DATA_W'(t + 1);
      end
      step();
      v5 = (t >= 1 && t <= 4);  d5 = DATA_W'(t);
      v0 = (t >= 8 && t <= 11); d0 = DATA_W'(t - 7);
      n_checks++; if (adc_tvalid[5] !== v5 || (v5 && adc_tdata[5*DATA_W +: DATA_W] !== d5)) begin
        n_fail++; $display("FAIL fanout_ch5 t=%0d: got v=%b d=%h expected v=%b d=%h", t, adc_tvalid[5], adc_tdata[5*DATA_W +: DATA_W], v5, d5);
      end
      n_checks++; if (adc_tvalid[0] !== v0 || (v0 && adc_tdata[0 +: DATA_W] !== d0)) begin
        n_fail++; $display("FAIL route_ch0 t=%0d: got v=%b d=%h expected v=%b d=%h", t, adc_tvalid[0], adc_tdata[0 +: DATA_W], v0, d0);
      end
    end
  endtask

  // The 4-bit delay field holds at most 15, the clamped value of 31; true
  // clamping of wider values is exercised on the second instance.
  task automatic test_mute_clamp();
    logic [NCHAN*DLY_W-1:0] d = '0;
    d[1*DLY_W +: DLY_W] = '1;
    load_cfg(ident_route(), d, 8'b0000_0010);
    dac_tvalid[1] = 1'b1;
    dac_tdata[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    step();
    idle();
    for (int t = 1; t <= 17; t++) begin
      bit v;
      step();
      v = (t == 16);
      n_checks++; if (adc_tvalid[1] !== v || adc_tdata[1*DATA_W +: DATA_W] !== '0) begin
        n_fail++; $display("FAIL mute_ch1 t=%0d: got v=%b d=%h expected v=%b d=0", t, adc_tvalid[1], adc_tdata[1*DATA_W +: DATA_W], v);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      dac_tvalid = NCHAN'($urandom);
      for (int j = 0; j < NCHAN; j++) dac_tdata[j*DATA_W +: DATA_W] = $urandom;
      adc_tready = ($urandom_range(0, 2) == 0) ? NCHAN'($urandom) : '1;
      cfg_route  = (NCHAN*SEL_W)'($urandom);
      cfg_delay  = (NCHAN*DLY_W)'($urandom);
      cfg_mute   = NCHAN'($urandom);
      cfg_load   = ($urandom_range(0, 19) == 0);
      drop_clr   = ($urandom_range(0, 49) == 0);
      step();
      for (int j = 0; j < NCHAN; j++) begin
        n_checks++; if (adc_tvalid[j] !== exp_v[j] || adc_tdata[j*DATA_W +: DATA_W] !== exp_d[j]) begin
          n_fail++; $display("FAIL rand_adc c=%0d ch=%0d: got v=%b d=%h expected v=%b d=%h", c, j, adc_tvalid[j], adc_tdata[j*DATA_W +: DATA_W], exp_v[j], exp_d[j]);
        end
        n_checks++; if (drop_count[j*16 +: 16] !== 16'(exp_cnt[j])) begin
          n_fail++; $display("FAIL rand_drop c=%0d ch=%0d: got %0d expected %0d", c, j, drop_count[j*16 +: 16], exp_cnt[j]);
        end
      end
      n_checks++; if (dac_tready !== {NCHAN{exp_rdy}}) begin n_fail++; $display("FAIL rand_tready c=%0d: got %b", c, dac_tready); end
    end
    idle();
    cfg_load = 1'b0; drop_clr = 1'b0; adc_tready = '1;
  endtask

  task automatic test_drops();
    load_cfg(ident_route(), '0, '0);
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    adc_tready = 8'b1111_1011;
    for (int t = 0; t < 3; t++) begin
      dac_tvalid[2] = 1'b1;
      dac_tdata[2*DATA_W +: DATA_W] = DATA_W'(32'h200 + t);
      step();
    end
    idle();
    repeat (3) step();
    n_checks++; if (drop_count[2*16 +: 16] !== 16'd3) begin n_fail++; $display("FAIL drop_three: got %0d expected 3", drop_count[2*16 +: 16]); end
    n_checks++; if (drop_count[0 +: 16] !== 16'd0) begin n_fail++; $display("FAIL drop_other: got %0d expected 0", drop_count[0 +: 16]); end
    dac_tvalid[2] = 1'b1;
    repeat (65540) step();
    n_checks++; if (drop_count[2*16 +: 16] !== 16'hFFFF) begin n_fail++; $display("FAIL drop_sat: got %h expected ffff", drop_count[2*16 +: 16]); end
    step();
    n_checks++; if (drop_count[2*16 +: 16] !== 16'hFFFF) begin n_fail++; $display("FAIL drop_sat_hold: got %h expected ffff", drop_count[2*16 +: 16]); end
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    n_checks++; if (drop_count[2*16 +: 16] !== 16'd0) begin n_fail++; $display("FAIL drop_clr_wins: got %0d expected 0", drop_count[2*16 +: 16]); end
    step();
    n_checks++; if (drop_count[2*16 +: 16] !== 16'd1) begin n_fail++; $display("FAIL drop_after_clr: got %0d expected 1", drop_count[2*16 +: 16]); end
    idle();
    adc_tready = '1;
  endtask

  task automatic test_reset_midstream();
    logic [NCHAN*DLY_W-1:0] d = '0;
    d[4*DLY_W +: DLY_W] = 4'd10;
    load_cfg(ident_route(), d, '0);
    for (int t = 0; t < 5; t++) begin
      dac_tvalid[4] = 1'b1;
      dac_tdata[4*DATA_W +: DATA_W] = DATA_W'(32'h400 + t);
      step();
    end
    idle();
    repeat (2) step();
    #2 areset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (dac_tready !== '0) begin n_fail++; $display("FAIL mid_rst_tready: got %b expected 0", dac_tready); end
    n_checks++; if (adc_tvalid !== '0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", adc_tvalid); end
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;
    n_checks++; if (dac_tready !== '0) begin n_fail++; $display("FAIL mid_rel_early: got %b expected 0", dac_tready); end
    step();
    n_checks++; if (dac_tready !== '1) begin n_fail++; $display("FAIL mid_rel_tready: got %b expected all 1", dac_tready); end
    for (int t = 0; t < 20; t++) begin
      step();
      n_checks++; if (adc_tvalid[4] !== 1'b0) begin n_fail++; $display("FAIL mid_ghost t=%0d: got 1 expected 0", t); end
    end
    // Reset must also restore delay 0 on ch4.
    dac_tvalid[4] = 1'b1;
    dac_tdata[4*DATA_W +: DATA_W] = 32'h0BAD_F00D;
    step();
    idle();
    step();
    n_checks++; if (adc_tvalid[4] !== 1'b1 || adc_tdata[4*DATA_W +: DATA_W] !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL mid_cfg_default: got v=%b d=%h expected v=1 d=0badf00d", adc_tvalid[4], adc_tdata[4*DATA_W +: DATA_W]);
    end
  endtask

  task automatic test_guards();
    for (int j = 0; j < G_N; j++) g_cfg_route[j*3 +: 3] = 3'(j);
    g_cfg_route[0 +: 3] = 3'd7;
    g_cfg_route[3 +: 3] = 3'd3;
    g_cfg_delay = '0;
    g_cfg_delay[0 +: 4] = 4'd14;
    g_cfg_load = 1'b1;
    step();
    g_cfg_load = 1'b0;
    g_cfg_route = '0;
    g_dac_tvalid = 6'b00_1001;
    g_dac_tdata[0 +: G_W] = 8'h3C;
    g_dac_tdata[3*G_W +: G_W] = 8'h5A;
    step();
    g_dac_tvalid = '0;
    g_dac_tdata = '0;
    for (int t = 1; t <= 13; t++) begin
      bit v0, v1;
      step();
      v0 = (t == 12);
      v1 = (t == 1);
      n_checks++; if (g_adc_tvalid[0] !== v0 || (v0 && g_adc_tdata[0 +: G_W] !== 8'h3C)) begin
        n_fail++; $display("FAIL guard_ch0 t=%0d: got v=%b d=%h expected v=%b d=3c", t, g_adc_tvalid[0], g_adc_tdata[0 +: G_W], v0);
      end
      n_checks++; if (g_adc_tvalid[1] !== v1 || (v1 && g_adc_tdata[G_W +: G_W] !== 8'h5A)) begin
        n_fail++; $display("FAIL guard_ch1 t=%0d: got v=%b d=%h expected v=%b d=5a", t, g_adc_tvalid[1], g_adc_tdata[G_W +: G_W], v1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_route_delay();
    test_mute_clamp();
    test_random();
    test_drops();
    test_reset_midstream();
    test_guards();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
